// File: rtl/input_debounce_pkg.sv
// Shared constants and helpers for the two-channel input debouncer.
// Optional edge-pulse outputs are enabled by defining DB_EDGE_PULSE_EN.
package debounce_pkg;

  localparam int DB_N_CH             = 2;
  localparam int DB_DEBOUNCE_DEFAULT = 4;

  typedef logic [DB_N_CH-1:0] db_vec_t;

  // Counter width for a given window; a one-cycle window still needs one bit.
  function automatic int db_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_debounce_if.sv
// Raw/debounced level bundle between the board pins and the logic_test operands.
// With DB_EDGE_PULSE_EN defined the bundle also carries rise/fall pulses.
interface input_debounce_if;
  import debounce_pkg::*;

  db_vec_t DB_i_raw;
  db_vec_t DB_o_level;
`ifdef DB_EDGE_PULSE_EN
  db_vec_t DB_o_rise;
  db_vec_t DB_o_fall;

  modport master (output DB_i_raw, input DB_o_level, input DB_o_rise, input DB_o_fall);
  modport slave  (input DB_i_raw, output DB_o_level, output DB_o_rise, output DB_o_fall);
`else
  modport master (output DB_i_raw, input DB_o_level);
  modport slave  (input DB_i_raw, output DB_o_level);
`endif

endinterface

// File: rtl/input_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, registered level.
// With DB_EDGE_PULSE_EN defined, also registered one-cycle rise/fall pulses.
module debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
`ifdef DB_EDGE_PULSE_EN
  ,
  output logic o_rise,
  output logic o_fall
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Any cycle where s2 agrees with the held level restarts the window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

`ifdef DB_EDGE_PULSE_EN
  logic r_level_d;
  logic r_rise;
  logic r_fall;

  // Delayed copy resets to 0 so leaving reset never looks like an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      r_fall    <= ~r_level & r_level_d;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`endif

endmodule

// File: rtl/input_debounce.sv
// Two independent debounce channels feeding logic_test's LT_i_0 / LT_i_1.
// Define DB_EDGE_PULSE_EN to add the DB_o_rise / DB_o_fall pulse outputs.
module input_debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DB_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = db_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic             DB_i_clk,
  input  logic             DB_i_rst_n,
  input_debounce_if.slave  db
);

  // Bit 0 drives LT_i_0, bit 1 drives LT_i_1.
  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch0 (
    .i_clk   (DB_i_clk),
    .i_rst_n (DB_i_rst_n),
    .i_raw   (db.DB_i_raw[0]),
    .o_level (db.DB_o_level[0])
`ifdef DB_EDGE_PULSE_EN
    ,
    .o_rise  (db.DB_o_rise[0]),
    .o_fall  (db.DB_o_fall[0])
`endif
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch1 (
    .i_clk   (DB_i_clk),
    .i_rst_n (DB_i_rst_n),
    .i_raw   (db.DB_i_raw[1]),
    .o_level (db.DB_o_level[1])
`ifdef DB_EDGE_PULSE_EN
    ,
    .o_rise  (db.DB_o_rise[1]),
    .o_fall  (db.DB_o_fall[1])
`endif
  );

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Two-channel input conditioner feeding the logic_test gate block.
- Takes raw, asynchronous board switch/button levels and drives clean, debounced levels onto logic_test's two operand inputs (LT_i_0, LT_i_1).
- Each channel has a 2-flop synchronizer followed by a counter-based stability filter.
- Channels are independent.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles an input must hold a new level before the output follows; legal range >= 1.
- CNT_W, default 2: counter width, equal to $clog2(DEBOUNCE_CYCLES), minimum 1.

Ports:
- DB_i_clk  input  1  single system clock, rising edge.
- DB_i_rst_n  input  1  asynchronous, active-low reset.
- DB_i_raw  input  2  raw pin levels; bit0 -> LT_i_0, bit1 -> LT_i_1.
- DB_o_level  output  2  debounced levels.
- DB_o_rise  output  2  one-cycle rising-edge pulse; present only with DB_EDGE_PULSE_EN.
- DB_o_fall  output  2  one-cycle falling-edge pulse; present only with DB_EDGE_PULSE_EN.

Behaviour:
- Reset: asserting DB_i_rst_n low immediately clears all state, whatever the clock is doing:
  - sync stages s1/s2 = 0
  - counters = 0
  - DB_o_level = 2'b00
  - DB_o_rise / DB_o_fall = 2'b00
- Release from reset is synchronous to the next rising edge. No output glitch occurs during reset.
- Synchronizer: each edge, s1 <= DB_i_raw and s2 <= s1. Only s2 feeds the filter; DB_i_raw is never used combinationally.
- Filter, per channel n, on each edge:
  - If s2[n] == level[n]: cnt[n] <= 0.
  - Else if cnt[n] == DEBOUNCE_CYCLES-1: level[n] <= s2[n] and cnt[n] <= 0.
  - Else: cnt[n] <= cnt[n]+1.
- Latency: a raw level first captured into s1 at edge k, and held, appears on DB_o_level after edge k+1+DEBOUNCE_CYCLES. For the default value 4, that is edge k+5.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES cycles at s2 resets the counter. The output never toggles.
- Bounce inside the window restarts the count from 0 on the first matching cycle.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- DEBOUNCE_CYCLES=1: the output follows s2 with one register stage, flipping at edge k+2.
- Both channels changing in the same cycle are handled fully in parallel; there is no arbitration.
- Outputs are registered only, with no combinational path from input to output.

Optional Feature:
- Macro: DB_EDGE_PULSE_EN.
- Defined:
  - DB_o_rise[n] is 1 for exactly one cycle, in the cycle after level[n] goes 0->1.
  - DB_o_fall[n] behaves the same for 1->0.
  - Both pulses are registered from level and a one-cycle-delayed copy of level. The delayed copy resets to 0, so no pulse fires at reset release.
- Undefined: DB_o_rise, DB_o_fall and the delayed-level registers do not exist. Port list is clk, rst_n, raw, level only.

Decomposition:
- Package debounce_pkg holds:
  - DB_N_CH = 2
  - DB_DEBOUNCE_DEFAULT = 4
  - function/constant for CNT_W derivation
- Sub-module debounce_ch: one channel with sync, counter and level (plus the edge registers when the macro is on). It is instantiated twice by input_debounce with identical parameters.
- Top-level input_debounce contains only instantiation and bit wiring; its output connects straight to logic_test.

Test Plan (DEBOUNCE_CYCLES=4, 10-unit clock):
- Reset: hold DB_i_rst_n=0 with DB_i_raw=2'b11 for 5 cycles -> DB_o_level=2'b00 throughout. Release, hold raw 2'b11 from the edge that captures it (k) -> level becomes 2'b11 after edge k+5, not before.
- Glitch rejection: level=00, pulse raw[0]=1 for 3 cycles then 0 -> level stays 00 and cnt[0] returns to 0. Repeat with a 4-cycle pulse -> level[0] goes to 1 for a valid window, then returns to 0 five edges after the raw fall.
- Bounce: raw[1] toggles 1,0,1,1,1,1,1 on successive cycles -> level[1] rises only after 4 consecutive synchronized 1s, i.e. 5 edges after the final 0->1 capture.
- Independence/simultaneous: sweep raw 00,01,10,11 holding each 10 cycles (the same sequence the gate test uses) -> level tracks each value 5 edges late, with no cross-channel coupling.
- Async reset mid-count: raw[0]=1, assert rst_n low after 2 count cycles, between clock edges -> level and counters clear immediately. After release, the full 5-edge latency applies again.
- DB_EDGE_PULSE_EN: level[0] 0->1 -> DB_o_rise[0]=1 for exactly one cycle, DB_o_fall=00. For a 1->0 change, DB_o_fall[0] pulses once. No pulses at reset release.
